// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: drains a show-ahead byte FIFO onto an 8N1 UART line with optional parity
module uart_tx_fifo_drain #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_ren,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = CPB > 1 ? $clog2(CPB) : 1;
  localparam int BW  = $clog2(DATA_WIDTH + 1);
  if (CPB < 2) begin : g_bad_baud
    $error("CLK_FREQ/BAUD must be at least 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         idx;
  logic [DATA_WIDTH-1:0] sh, sh_nxt;
  logic                  par, bit_end;
  assign bit_end    = cnt == CW'(CPB - 1);
  assign sh_nxt     = sh >> 1;
  assign fifo_ren   = state == IDLE && !fifo_empty && !rst;
  assign busy       = state != IDLE;
  assign frame_done = state == STOP && bit_end && idx == BW'(STOP_BITS - 1);
  // idx counts data bits in DATA and stop bits in STOP
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx    <= 1'b1;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      par   <= 1'b0;
    end else begin
      cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (fifo_ren) begin
          sh    <= fifo_rdata;
          par   <= ^fifo_rdata ^ (PARITY == 2);
          idx   <= '0;
          tx    <= 1'b0;
          state <= START;
        end
        START: if (bit_end) begin
          tx    <= sh[0];
          state <= DATA;
        end
        DATA: if (bit_end) begin
          if (idx == BW'(DATA_WIDTH - 1)) begin
            idx   <= '0;
            tx    <= PARITY != 0 ? par : 1'b1;
            state <= PARITY != 0 ? PAR : STOP;
          end else begin
            idx <= idx + 1'b1;
            sh  <= sh_nxt;
            tx  <= sh_nxt[0];
          end
        end
        PAR: if (bit_end) begin
          tx    <= 1'b1;
          state <= STOP;
        end
        STOP: if (bit_end) begin
          idx   <= frame_done ? '0 : idx + 1'b1;
          state <= frame_done ? IDLE : STOP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: four configs (none/even/odd parity, two stop bits) checked by per-line UART receiver monitors
module tb_uart_tx_fifo_drain;
  logic       clk = 1'b0;
  logic [3:0] rst, fifo_empty, fifo_ren, tx, busy, frame_done;
  logic [7:0] rdata[4];
  logic [7:0] fq[4][$];
  logic [8:0] eq[4][$];
  int pops[4];
  int checks = 0, errors = 0;
  int bren, btx, bbusy, first, last, nbusy, t;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_fifo_drain #(
      .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_WIDTH(8),
      .PARITY(g == 1 ? 1 : g == 2 ? 2 : 0), .STOP_BITS(g == 3 ? 2 : 1)
    ) dut (
      .clk(clk), .rst(rst[g]), .fifo_empty(fifo_empty[g]), .fifo_rdata(rdata[g]),
      .fifo_ren(fifo_ren[g]), .tx(tx[g]), .busy(busy[g]), .frame_done(frame_done[g])
    );
  end

  // show-ahead FIFO model: pop on the edge where fifo_ren is high
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (fifo_ren[k] === 1'b1) begin
        void'(fq[k].pop_front());
        pops[k]++;
      end
      fifo_empty[k] <= fq[k].size() == 0;
      rdata[k]      <= fq[k].size() != 0 ? fq[k][0] : 8'h00;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic p, input bit expect_it);
    fq[k].push_back(d);
    if (expect_it) eq[k].push_back({p, d});
  endtask

  task automatic mon(input int k);
    int n, c, nfd, fdc, nb, np;
    logic [11:0] b;
    logic [8:0] e;
    logic fr;
    bit abort;
    forever begin
      @(negedge clk);
      if (tx[k] !== 1'b0 || rst[k]) continue;
      np = (k == 1 || k == 2) ? 1 : 0;
      n = (k == 0 ? 10 : 11) * 10;
      c = 1; b = '1; nfd = 0; fdc = 0; nb = 0; abort = 0;
      forever begin
        if (rst[k]) begin
          abort = 1;
          break;
        end
        if (busy[k]) nb++;
        if (frame_done[k]) begin
          nfd++;
          fdc = c;
        end
        if (c % 10 == 5) b[c / 10] = tx[k];
        if (c == n) break;
        @(negedge clk);
        c++;
      end
      if (abort) continue;
      @(negedge clk);
      chk($sformatf("idle_after_frame%0d", k), {busy[k], tx[k], frame_done[k]}, 3'b010);
      chk($sformatf("frame_expected%0d", k), eq[k].size() != 0, 1);
      if (eq[k].size() == 0) continue;
      e = eq[k].pop_front();
      fr = ~b[0];
      for (int i = 9 + np; i < n / 10; i++) fr &= b[i];
      chk($sformatf("data_parity%0d", k), {np != 0 ? b[9] : 1'b0, b[8:1]}, e);
      chk($sformatf("start_stop%0d", k), fr, 1);
      chk($sformatf("frame_done_cycle%0d", k), fdc, n);
      chk($sformatf("frame_done_count%0d", k), nfd, 1);
      chk($sformatf("busy_cycles%0d", k), nb, n);
    end
  endtask

  task automatic wait_idle(input int k);
    int w;
    for (w = 0; w < 3000; w++) begin
      @(negedge clk);
      if (fq[k].size() == 0 && eq[k].size() == 0 && !busy[k] && fifo_empty[k]) break;
    end
    chk($sformatf("idle_reached%0d", k), w < 3000, 1);
  endtask

  initial begin
    rst = '1;
    fork
      mon(0); mon(1); mon(2); mon(3);
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", tx, 4'hF);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_ren", fifo_ren, 0);
    @(posedge clk); #2 rst = '0;
    bren = 0; btx = 0; bbusy = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      bren += fifo_ren != 0;
      btx += tx != 4'hF;
      bbusy += busy != 0;
    end
    chk("empty_ren", bren, 0);
    chk("empty_tx", btx, 0);
    chk("empty_busy", bbusy, 0);
    @(posedge clk); #2 push(0, 8'h55, 1'b0, 1);
    wait_idle(0);
    chk("single_pops", pops[0], 1);
    @(posedge clk); #2;
    push(0, 8'hA5, 1'b0, 1);
    push(0, 8'h0F, 1'b0, 1);
    push(0, 8'hFF, 1'b0, 1);
    first = -1; last = -1; nbusy = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy[0]) begin
        if (first < 0) first = i;
        last = i;
        nbusy++;
      end
    end
    chk("b2b_span", last - first + 1, 302);
    chk("b2b_busy", nbusy, 300);
    chk("b2b_pops", pops[0], 4);
    chk("b2b_final", {fifo_empty[0], tx[0], busy[0]}, 3'b110);
    @(posedge clk); #2;
    push(1, 8'h07, 1'b1, 1);
    push(1, 8'h00, 1'b0, 1);
    push(2, 8'h07, 1'b0, 1);
    push(3, 8'h80, 1'b0, 1);
    wait_idle(1); wait_idle(2); wait_idle(3);
    chk("even_pops", pops[1], 2);
    chk("odd_pops", pops[2], 1);
    chk("stop2_pops", pops[3], 1);
    @(posedge clk); #2;
    push(0, 8'h3C, 1'b0, 0);
    push(0, 8'h5A, 1'b0, 1);
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (tx[0] == 1'b0) break;
    end
    chk("abort_start_seen", t < 200, 1);
    repeat (34) @(negedge clk);
    #1 rst[0] = 1'b1;
    @(negedge clk);
    chk("abort_tx", tx[0], 1);
    chk("abort_busy", busy[0], 0);
    chk("abort_ren", {fifo_empty[0], fifo_ren[0]}, 2'b00);
    @(negedge clk);
    chk("abort_ren_hold", fifo_ren[0], 0);
    #1 rst[0] = 1'b0;
    wait_idle(0);
    chk("abort_pops", pops[0], 6);
    for (int k = 0; k < 4; k++) chk($sformatf("leftover%0d", k), eq[k].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
